// File: rtl/serial_adder.sv
// Bit-serial adder: {carry,sum} = a + b + cin, one bit per clock, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             carry,
    output logic             ovf
`else
    output logic             carry
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (y & c) | (x & c);
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_load;
    logic             w_last;
    logic             w_s;
    logic             w_c_nxt;
    logic [WIDTH-1:0] w_res_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-2:0] r_res;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    assign w_s       = fa_sum(r_a[0], r_b[0], r_c);
    assign w_c_nxt   = fa_carry(r_a[0], r_b[0], r_c);
    assign w_res_nxt = {w_s, r_res};
    assign w_last    = (r_state == S_SHIFT) && (r_cnt == LAST_BIT);

    // Next-state logic; start is honoured only in IDLE and DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SHIFT;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = S_SHIFT;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_load      = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand, carry, counter and partial-result shift registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
            r_res <= '0;
        end else if (w_load) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= cin;
            r_cnt <= '0;
            r_res <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_c   <= w_c_nxt;
            r_res <= w_res_nxt[WIDTH-1:1];
            if (!w_last) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Status flags follow the next state; results load only on the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_SHIFT);
            r_done <= (w_state_nxt == S_DONE);
            if (w_last) begin
                r_sum   <= w_res_nxt;
                r_carry <= w_c_nxt;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_c ^ w_c_nxt;
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy  = r_busy;
    assign done  = r_done;
    assign sum   = r_sum;
    assign carry = r_carry;

endmodule
